i2s_sample_feeder: RTL and testbench

Sample-rate buffer directly upstream of the `i2s` transmitter. It accepts 16-bit mono samples from the synth voice/mixer path over a valid/ready handshake and stores them in a small FIFO. It presents exactly one sample per I2S frame on `audio_data`, advancing on each left-channel frame start detected from the transmitter's `word_clock`, so the left and right slots of a frame always carry the same sample. It also supplies the synth with a frame tick and underrun status.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/i2s_sample_feeder_if.sv | 31 +++
 rtl/sync_fifo.sv | 83 ++++++++
 rtl/i2s_sample_feeder.sv | 149 ++++++++++++++
 tb/tb_i2s_sample_feeder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the synth-to-I2S audio path.
//   SAMPLE_WIDTH        : sample width, shared with the i2s transmitter
//   sample_t            : one audio sample
//   UNDERRUN_CNT_WIDTH  : width of the underrun frame counter
//   UNDERRUN_CNT_MAX    : value at which the underrun counter saturates
//   underrun_cnt_inc()  : saturating increment for the underrun counter
// ----------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_WIDTH = 16;
    typedef logic [SAMPLE_WIDTH-1:0] sample_t;

    localparam int UNDERRUN_CNT_WIDTH = 16;
    typedef logic [UNDERRUN_CNT_WIDTH-1:0] underrun_cnt_t;
    localparam underrun_cnt_t UNDERRUN_CNT_MAX = {UNDERRUN_CNT_WIDTH{1'b1}};

    // Holds at the maximum instead of wrapping back to zero.
    function automatic underrun_cnt_t underrun_cnt_inc(input underrun_cnt_t value);
        return (value == UNDERRUN_CNT_MAX) ? value : value + underrun_cnt_t'(1);
    endfunction

endpackage

// File: rtl/i2s_sample_feeder_if.sv
// ----------------------------------------------------------------------------
// i2s_sample_feeder_if
// Valid/ready sample stream from the synth voice/mixer path into the feeder.
//   in_sample : sample being offered
//   in_valid  : in_sample is valid
//   in_ready  : receiver can take a sample; transfer when in_valid & in_ready
// Modports:
//   master : synth side (drives in_sample/in_valid, observes in_ready)
//   slave  : feeder side (observes in_sample/in_valid, drives in_ready)
// ----------------------------------------------------------------------------
interface i2s_sample_feeder_if #(
    parameter int WIDTH = audio_pkg::SAMPLE_WIDTH
);

    logic [WIDTH-1:0] in_sample;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_sample,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_sample,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered occupancy count.
//   sys_clock  : clock
//   reset      : asynchronous active-low reset (pointers and count only)
//   push       : write push_data (ignored while full)
//   push_data  : data to write
//   pop        : drop the head entry (ignored while empty)
//   head_data  : current head entry
//   full       : count == DEPTH
//   empty      : count == 0
//   count      : number of stored entries
// Storage contents are never reset; only the pointers and count are.
// full/empty are decoded from the registered count so they never depend
// combinationally on push or pop.
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             sys_clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // A pop on an empty FIFO is dropped even if a push lands in the same
    // cycle: the new entry only becomes visible from the next cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge sys_clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // The consumer registers the head on pop, so the read port stays
    // registered at the output of the feeder.
    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/i2s_sample_feeder.sv
// ----------------------------------------------------------------------------
// i2s_sample_feeder
// Sample-rate buffer in front of the i2s transmitter. Buffers mono samples
// from the synth and presents one per I2S frame on audio_data, advancing at
// each left-channel frame start (synchronised falling edge of word_clock),
// so both slots of a frame carry the same sample.
//   sys_clock      : system clock (only clock)
//   reset          : asynchronous active-low reset
//   in_bus         : valid/ready sample stream (slave side)
//   word_clock     : i2s word select, asynchronous; 0 = left, 1 = right
//   audio_data     : sample presented to i2s, changes only at frame start
//   frame_tick     : one-cycle pulse at each frame start
//   underrun       : sticky, set when a frame starts with the FIFO empty
//   clear_underrun : synchronous clear of underrun and underrun_count
//   underrun_count : saturating count of underrun frames
//   fill_level     : number of buffered samples
// ----------------------------------------------------------------------------
module i2s_sample_feeder
    import audio_pkg::*;
#(
    parameter int  DEPTH  = 16,
    parameter int  WIDTH  = SAMPLE_WIDTH,
    localparam int FILL_W = $clog2(DEPTH + 1)
) (
    input  logic                 sys_clock,
    input  logic                 reset,
    i2s_sample_feeder_if.slave   in_bus,
    input  logic                 word_clock,
    output logic [WIDTH-1:0]     audio_data,
    output logic                 frame_tick,
    output logic                 underrun,
    input  logic                 clear_underrun,
    output underrun_cnt_t        underrun_count,
    output logic [FILL_W-1:0]    fill_level
);

    // Two synchroniser stages plus one history stage for edge detection.
    localparam int SYNC_STAGES = 3;

    logic [SYNC_STAGES-1:0] wc_sync_reg;
    logic [SYNC_STAGES-1:0] wc_sync_next;
    logic                   frame_start;

    logic [WIDTH-1:0]       fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic [WIDTH-1:0]       audio_data_reg;
    logic [WIDTH-1:0]       audio_data_next;
    logic                   frame_tick_reg;
    logic                   underrun_reg;
    logic                   underrun_next;
    underrun_cnt_t          underrun_count_reg;
    underrun_cnt_t          underrun_count_next;

    // ------------------------------------------------------------------
    // word_clock synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_wc_sync
            if (gi == 0) begin : g_first
                assign wc_sync_next[gi] = word_clock;
            end else begin : g_chain
                assign wc_sync_next[gi] = wc_sync_reg[gi-1];
            end
        end
    endgenerate

    // Flops reset to 0, so a word_clock that is low at reset release does
    // not look like a falling edge.
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            wc_sync_reg <= '0;
        end else begin
            wc_sync_reg <= wc_sync_next;
        end
    end

    // Right-to-left transition of the synchronised word clock.
    assign frame_start = wc_sync_reg[SYNC_STAGES-1] & ~wc_sync_reg[SYNC_STAGES-2];

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .sys_clock (sys_clock),
        .reset     (reset),
        .push      (in_bus.in_valid),
        .push_data (in_bus.in_sample),
        .pop       (frame_start),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fill_level)
    );

    // Registered-state decode only; never looks at in_valid.
    assign in_bus.in_ready = ~fifo_full;

    // ------------------------------------------------------------------
    // Output sample register and underrun tracking
    // ------------------------------------------------------------------
    always_comb begin
        audio_data_next     = audio_data_reg;
        underrun_next       = underrun_reg;
        underrun_count_next = underrun_count_reg;

        if (frame_start && !fifo_empty) begin
            audio_data_next = fifo_head;
        end

        // An underrun frame start overrides a coincident clear, leaving
        // exactly this frame counted.
        if (frame_start && fifo_empty) begin
            underrun_next       = 1'b1;
            underrun_count_next = clear_underrun ? underrun_cnt_t'(1)
                                                 : underrun_cnt_inc(underrun_count_reg);
        end else if (clear_underrun) begin
            underrun_next       = 1'b0;
            underrun_count_next = '0;
        end
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            audio_data_reg     <= '0;
            frame_tick_reg     <= 1'b0;
            underrun_reg       <= 1'b0;
            underrun_count_reg <= '0;
        end else begin
            audio_data_reg     <= audio_data_next;
            frame_tick_reg     <= frame_start;
            underrun_reg       <= underrun_next;
            underrun_count_reg <= underrun_count_next;
        end
    end

    // frame_tick is registered alongside audio_data so the pulse lands in
    // the same cycle the new sample appears.
    assign audio_data     = audio_data_reg;
    assign frame_tick     = frame_tick_reg;
    assign underrun       = underrun_reg;
    assign underrun_count = underrun_count_reg;

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// ----------------------------------------------------------------------------
// tb_i2s_sample_feeder
// Directed scenarios followed by a randomised stream. Stimulus records every
// accepted sample and word_clock falling edge; a negedge monitor keeps a
// queue-based model of the buffer and checks the DUT against it each cycle.
// ----------------------------------------------------------------------------
module tb_i2s_sample_feeder;
    import audio_pkg::*;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;

    logic             sys_clock      = 1'b0;
    logic             reset          = 1'b1;
    logic             word_clock     = 1'b0;
    logic             clear_underrun = 1'b0;
    logic [WIDTH-1:0] audio_data;
    logic             frame_tick;
    logic             underrun;
    logic [15:0]      underrun_count;
    logic [4:0]       fill_level;

    i2s_sample_feeder_if #(.WIDTH(WIDTH)) bus ();

    i2s_sample_feeder #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .sys_clock      (sys_clock),
        .reset          (reset),
        .in_bus         (bus),
        .word_clock     (word_clock),
        .audio_data     (audio_data),
        .frame_tick     (frame_tick),
        .underrun       (underrun),
        .clear_underrun (clear_underrun),
        .underrun_count (underrun_count),
        .fill_level     (fill_level)
    );

    always #5 sys_clock = ~sys_clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge sys_clock) cyc <= cyc + 1;

    // Reference model state
    sample_t     model_q[$];
    sample_t     model_audio = '0;
    bit          model_under = 1'b0;
    logic [15:0] model_cnt   = '0;
    int          edge_q[$];
    bit          pend_push   = 1'b0;
    bit          pend_clear  = 1'b0;
    sample_t     pend_sample = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard. Inputs seen at a negedge take effect at the
    // following posedge, so they are held as "pending" and applied after
    // any frame start reported at the next negedge.
    // ------------------------------------------------------------------
    always @(negedge sys_clock) begin
        bit uf;
        int lat;
        uf = 1'b0;
        if (!reset) begin
            model_q.delete();
            edge_q.delete();
            model_audio = '0;
            model_under = 1'b0;
            model_cnt   = '0;
        end else begin
            if (frame_tick) begin
                n_vec++;
                if (edge_q.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_tick: frame_tick=1 with no word_clock fall outstanding (cycle %0d)", cyc);
                end else begin
                    lat = cyc - edge_q.pop_front();
                    if (lat < 3 || lat > 4) begin
                        n_err++;
                        $display("FAIL tick_latency: got %0d cycles, expected 3..4 (cycle %0d)", lat, cyc);
                    end
                end
                if (model_q.size() > 0) model_audio = model_q.pop_front();
                else                    uf = 1'b1;
            end
            if (edge_q.size() > 0 && (cyc - edge_q[0]) > 4) begin
                n_vec++;
                n_err++;
                $display("FAIL missing_tick: no frame_tick %0d cycles after fall, expected within 4 (cycle %0d)",
                         cyc - edge_q[0], cyc);
                void'(edge_q.pop_front());
            end
            if (uf) begin
                model_under = 1'b1;
                model_cnt   = pend_clear ? 16'd1 : ((model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'd1);
            end else if (pend_clear) begin
                model_under = 1'b0;
                model_cnt   = '0;
            end
            if (pend_push) model_q.push_back(pend_sample);
        end

        chk("audio_data",     audio_data,      model_audio);
        chk("underrun",       underrun,        model_under);
        chk("underrun_count", underrun_count,  model_cnt);
        chk("fill_level",     fill_level,      model_q.size());
        chk("in_ready",       bus.in_ready,    (model_q.size() < DEPTH) ? 1 : 0);

        pend_push   = reset && bus.in_valid && (model_q.size() < DEPTH);
        pend_sample = bus.in_sample;
        pend_clear  = reset && clear_underrun;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all drives land 1 time unit after a posedge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic push(input logic [15:0] val);
        bit done;
        done = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sample = val;
        for (int k = 0; k < 64 && !done; k++) begin
            done = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL push_timeout: sample 0x%0h not accepted, in_ready=%0b, expected acceptance within 64 cycles",
                     val, bus.in_ready);
        end
    endtask

    task automatic fall();
        word_clock = 1'b0;
        edge_q.push_back(cyc);
    endtask

    task automatic frame(input int half);
        word_clock = 1'b1;
        repeat (half) tick();
        fall();
        repeat (half) tick();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int half_left;
        bit hi_rate;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;

        #1 reset = 1'b0;
        repeat (3) @(posedge sys_clock);
        #1 reset = 1'b1;
        repeat (2) tick();

        // Edge qualification: rising word_clock on an empty FIFO.
        word_clock = 1'b1;
        repeat (10) tick();

        // Normal flow
        push(16'd1);
        push(16'd2);
        push(16'd3);
        repeat (3) frame(8);

        // Underrun and clear
        push(16'h1234);
        repeat (3) frame(8);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        repeat (3) tick();

        // Full: one extra sample accepted per pop while in_valid is held
        for (int i = 0; i < DEPTH; i++) push(16'($urandom));
        bus.in_valid  = 1'b1;
        bus.in_sample = 16'hBEEF;
        repeat (4) tick();
        frame(8);
        bus.in_valid = 1'b0;
        repeat (DEPTH) frame(8);

        // Push coinciding with a frame start on an empty FIFO
        word_clock = 1'b1;
        repeat (8) tick();
        fall();
        tick();
        tick();
        bus.in_valid  = 1'b1;
        bus.in_sample = 16'hAAAA;
        tick();
        bus.in_valid = 1'b0;
        repeat (6) tick();
        frame(8);

        // Clear coinciding with an underrun frame start
        word_clock = 1'b1;
        repeat (8) tick();
        fall();
        tick();
        tick();
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        repeat (6) tick();

        // Reset mid-stream
        push(16'h0042);
        frame(8);
        for (int i = 0; i < 5; i++) push(16'($urandom));
        repeat (3) tick();
        @(posedge sys_clock);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_audio_data",     audio_data,     0);
        chk("async_rst_frame_tick",     frame_tick,     0);
        chk("async_rst_underrun",       underrun,       0);
        chk("async_rst_underrun_count", underrun_count, 0);
        chk("async_rst_fill_level",     fill_level,     0);
        chk("async_rst_in_ready",       bus.in_ready,   1);
        repeat (2) @(posedge sys_clock);
        #1 reset = 1'b1;
        repeat (2) tick();
        frame(8);

        // Randomised stream: a filling phase then a starving phase
        half_left = 10;
        for (int i = 0; i < 3000; i++) begin
            hi_rate        = (i < 1500);
            bus.in_valid   = hi_rate ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
            bus.in_sample  = 16'($urandom);
            clear_underrun = ($urandom_range(0, 63) == 0);
            half_left--;
            if (half_left == 0) begin
                if (word_clock) fall();
                else            word_clock = 1'b1;
                half_left = $urandom_range(6, 20);
            end
            tick();
        end
        bus.in_valid   = 1'b0;
        clear_underrun = 1'b0;
        repeat (10) tick();

        n_vec++;
        if (edge_q.size() != 0) begin
            n_err++;
            $display("FAIL end_ticks: %0d word_clock falls without frame_tick, expected 0", edge_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
